// File: rtl/delta_deskew_collector_pkg.sv
// ============================================================================
// Module      : delta_deskew_collector_pkg
// Description : Shared backprop (gdo) constants and packed-bus lane helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package delta_deskew_collector_pkg;

    // gdo elements are Q8.8 fixed point
    localparam int c_data_size = 16;

    // LSB of lane `lane` in a bus of `lanes` elements; lane 0 sits at the MSB end.
    function automatic int lane_lsb(input int lane, input int lanes, input int dsize);
        return dsize * (lanes - 1 - lane);
    endfunction

endpackage

`default_nettype wire

// File: rtl/delta_deskew_collector_if.sv
// ============================================================================
// Module      : delta_deskew_collector_if
// Description : Skewed-input / aligned-output bundle of the deskew collector.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface delta_deskew_collector_if
    import delta_deskew_collector_pkg::*;
#(
    parameter int DATA_SIZE  = c_data_size,
    parameter int SIZE       = 3,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_row_w = DATA_SIZE * SIZE;
    localparam int c_idx_w = $clog2(SIZE) + 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    logic [c_row_w-1:0] in_data;
    logic               in_valid;
    logic               layer_start;
    logic [c_row_w-1:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_first;
    logic               out_last;
    logic [c_idx_w-1:0] out_row_idx;
    logic [c_cnt_w-1:0] fifo_count;
    logic               overflow;

    modport slave (
        input  in_data, in_valid, layer_start, out_ready,
        output out_data, out_valid, out_first, out_last, out_row_idx, fifo_count, overflow
    );

    modport master (
        output in_data, in_valid, layer_start, out_ready,
        input  out_data, out_valid, out_first, out_last, out_row_idx, fifo_count, overflow
    );

endinterface

`default_nettype wire

// File: rtl/delta_row_fifo.sv
// ============================================================================
// Module      : delta_row_fifo
// Description : Synchronous FIFO, async reset, extra pointer bit for full/empty.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module delta_row_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         push_data,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         head_data,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [c_ptr_w:0]  r_wr_ptr;
    logic [c_ptr_w:0]  r_rd_ptr;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic              w_do_push;
    logic              w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                   (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    assign head_data = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[c_ptr_w-1:0]] <= push_data;
                r_wr_ptr                     <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/delta_deskew_collector.sv
// ============================================================================
// Module      : delta_deskew_collector
// Description : Deskews systolic result rows, tags them and buffers in a FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module delta_deskew_collector
    import delta_deskew_collector_pkg::*;
#(
    parameter int DATA_SIZE  = c_data_size,
    parameter int SIZE       = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    delta_deskew_collector_if.slave    bus
);

    localparam int c_row_w = DATA_SIZE * SIZE;
    localparam int c_idx_w = $clog2(SIZE) + 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(SIZE - 1);

    typedef struct packed {
        logic [c_row_w-1:0] data;
        logic [c_idx_w-1:0] idx;
        logic               first;
        logic               last;
    } entry_t;

    localparam int c_entry_w = $bits(entry_t);

    logic [c_row_w-1:0] w_aligned;
    logic               w_dly_valid;
    logic               w_dly_start;
    logic [c_idx_w-1:0] r_row_idx;
    logic               r_started;
    logic [c_idx_w-1:0] w_next_idx;
    entry_t             w_wr_entry;
    entry_t             w_rd_entry;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic [c_cnt_w-1:0] w_count;
    logic               r_overflow;

    // Lane k arrives k cycles late, so it waits SIZE-1-k stages to line up with lane SIZE-1.
    for (genvar k = 0; k < SIZE; k++) begin : g_lane
        localparam int c_dly = SIZE - 1 - k;
        localparam int c_lsb = lane_lsb(k, SIZE, DATA_SIZE);

        if (c_dly == 0) begin : g_pass
            assign w_aligned[c_lsb +: DATA_SIZE] = bus.in_data[c_lsb +: DATA_SIZE];
        end else begin : g_dly
            logic [DATA_SIZE-1:0] r_pipe [c_dly];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < c_dly; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= bus.in_data[c_lsb +: DATA_SIZE];
                    for (int i = 1; i < c_dly; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_aligned[c_lsb +: DATA_SIZE] = r_pipe[c_dly-1];
        end
    end

    if (SIZE == 1) begin : g_ctl_pass
        assign w_dly_valid = bus.in_valid;
        assign w_dly_start = bus.layer_start;
    end else begin : g_ctl_dly
        logic [SIZE-2:0] r_valid_sr;
        logic [SIZE-2:0] r_start_sr;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_valid_sr <= '0;
                r_start_sr <= '0;
            end else begin
                r_valid_sr[0] <= bus.in_valid;
                r_start_sr[0] <= bus.in_valid && bus.layer_start;
                for (int i = 1; i < SIZE - 1; i++) begin
                    r_valid_sr[i] <= r_valid_sr[i-1];
                    r_start_sr[i] <= r_start_sr[i-1];
                end
            end
        end

        assign w_dly_valid = r_valid_sr[SIZE-2];
        assign w_dly_start = r_start_sr[SIZE-2];
    end

    // Until a row has been seen since reset, the next row restarts at index 0.
    always_comb begin
        w_next_idx = '0;
        if (!w_dly_start && r_started && (r_row_idx != c_last_idx)) begin
            w_next_idx = r_row_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_idx <= '0;
            r_started <= 1'b0;
        end else if (w_dly_valid) begin
            r_row_idx <= w_next_idx;
            r_started <= 1'b1;
        end
    end

    always_comb begin
        w_wr_entry       = '0;
        w_wr_entry.data  = w_aligned;
        w_wr_entry.idx   = w_next_idx;
        w_wr_entry.first = (w_next_idx == '0);
        w_wr_entry.last  = (w_next_idx == c_last_idx);
    end

    assign w_pop = !w_empty && bus.out_ready;

    delta_row_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .push      (w_dly_valid),
        .push_data (w_wr_entry),
        .pop       (w_pop),
        .head_data (w_rd_entry),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // Upstream cannot be stalled: a row landing on a full FIFO without a pop is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_dly_valid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign bus.out_data    = w_rd_entry.data;
    assign bus.out_row_idx = w_rd_entry.idx;
    assign bus.out_first   = w_rd_entry.first;
    assign bus.out_last    = w_rd_entry.last;
    assign bus.out_valid   = !w_empty;
    assign bus.fifo_count  = w_count;
    assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_delta_deskew_collector.sv
// ============================================================================
// Module      : tb_delta_deskew_collector
// Description : Directed bench for the deskew collector, size=3, depth=4.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_delta_deskew_collector;

    localparam int c_ds    = 16;
    localparam int c_size  = 3;
    localparam int c_depth = 4;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    logic [15:0] hist [0:2][0:2];

    delta_deskew_collector_if #(
        .DATA_SIZE  (c_ds),
        .SIZE       (c_size),
        .FIFO_DEPTH (c_depth)
    ) dut_if ();

    delta_deskew_collector #(
        .DATA_SIZE  (c_ds),
        .SIZE       (c_size),
        .FIFO_DEPTH (c_depth)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] row_lane(input int n, input int k);
        return 16'(((k + 1) << 8) | n);
    endfunction

    function automatic logic [47:0] row_vec(input int n);
        return {row_lane(n, 0), row_lane(n, 1), row_lane(n, 2)};
    endfunction

    // Drive one cycle of skewed input (lane k of the row launched k cycles ago), then wait a negedge.
    task automatic step(input logic v, input logic ls, input int n, input logic rdy);
        for (int j = 2; j > 0; j--) begin
            for (int k = 0; k < 3; k++) hist[j][k] = hist[j-1][k];
        end
        for (int k = 0; k < 3; k++) hist[0][k] = v ? row_lane(n, k) : 16'h0;
        dut_if.in_data     = {hist[0][0], hist[1][1], hist[2][2]};
        dut_if.in_valid    = v;
        dut_if.layer_start = ls;
        dut_if.out_ready   = rdy;
        @(negedge clk);
    endtask

    task automatic check_head(input string tag, input int n, input int idx, input logic first, input logic last);
        check_val({tag, ".valid"}, 64'(dut_if.out_valid), 64'd1);
        check_val({tag, ".data"},  64'(dut_if.out_data), 64'(row_vec(n)));
        check_val({tag, ".idx"},   64'(dut_if.out_row_idx), 64'(idx));
        check_val({tag, ".first"}, 64'(dut_if.out_first), 64'(first));
        check_val({tag, ".last"},  64'(dut_if.out_last), 64'(last));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int j = 0; j < 3; j++) for (int k = 0; k < 3; k++) hist[j][k] = 16'h0;
        dut_if.in_data     = '0;
        dut_if.in_valid    = 1'b0;
        dut_if.layer_start = 1'b0;
        dut_if.out_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        do_reset();
        check_val("rst.valid", 64'(dut_if.out_valid), 64'd0);
        check_val("rst.count", 64'(dut_if.fifo_count), 64'd0);
        check_val("rst.data",  64'(dut_if.out_data), 64'd0);
        check_val("rst.ovf",   64'(dut_if.overflow), 64'd0);

        // single row, latency
        step(1'b1, 1'b1, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        check_val("t1.early_valid", 64'(dut_if.out_valid), 64'd0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t1.head", 0, 0, 1'b1, 1'b0);
        check_val("t1.count", 64'(dut_if.fifo_count), 64'd1);
        step(1'b0, 1'b0, 0, 1'b1);
        check_val("t1.count_after_pop", 64'(dut_if.fifo_count), 64'd0);
        check_val("t1.valid_after_pop", 64'(dut_if.out_valid), 64'd0);

        // back-to-back rows, index wrap without layer_start
        step(1'b1, 1'b1, 1, 1'b1);
        step(1'b1, 1'b0, 2, 1'b1);
        step(1'b1, 1'b0, 3, 1'b1);
        check_head("t2.r1", 1, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4, 1'b1);
        check_head("t2.r2", 2, 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t2.r3", 3, 2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t2.r4", 4, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_val("t2.count_end", 64'(dut_if.fifo_count), 64'd0);

        // overflow: six rows, no drain
        do_reset();
        step(1'b1, 1'b1, 11, 1'b0);
        step(1'b1, 1'b0, 12, 1'b0);
        step(1'b1, 1'b0, 13, 1'b0);
        check_val("t3.count1", 64'(dut_if.fifo_count), 64'd1);
        step(1'b1, 1'b0, 14, 1'b0);
        step(1'b1, 1'b0, 15, 1'b0);
        step(1'b1, 1'b0, 16, 1'b0);
        check_val("t3.count4", 64'(dut_if.fifo_count), 64'd4);
        check_val("t3.ovf_before", 64'(dut_if.overflow), 64'd0);
        step(1'b0, 1'b0, 0, 1'b0);
        check_val("t3.ovf_set", 64'(dut_if.overflow), 64'd1);
        step(1'b0, 1'b0, 0, 1'b0);
        check_val("t3.count_sat", 64'(dut_if.fifo_count), 64'd4);
        check_head("t3.h11", 11, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t3.h12", 12, 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t3.h13", 13, 2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t3.h14", 14, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_val("t3.drained", 64'(dut_if.fifo_count), 64'd0);
        check_val("t3.valid_end", 64'(dut_if.out_valid), 64'd0);
        check_val("t3.ovf_sticky", 64'(dut_if.overflow), 64'd1);

        // full with simultaneous push and pop
        do_reset();
        step(1'b1, 1'b1, 21, 1'b0);
        step(1'b1, 1'b0, 22, 1'b0);
        step(1'b1, 1'b0, 23, 1'b0);
        step(1'b1, 1'b0, 24, 1'b0);
        step(1'b1, 1'b0, 25, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        check_val("t4.full", 64'(dut_if.fifo_count), 64'd4);
        step(1'b0, 1'b0, 0, 1'b1);
        check_val("t4.count_pp", 64'(dut_if.fifo_count), 64'd4);
        check_val("t4.ovf", 64'(dut_if.overflow), 64'd0);
        check_head("t4.h22", 22, 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t4.h23", 23, 2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t4.h24", 24, 0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_head("t4.h25", 25, 1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check_val("t4.drained", 64'(dut_if.fifo_count), 64'd0);

        // reset while a row is half-way through the delay line
        do_reset();
        step(1'b1, 1'b1, 30, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        check_head("t5.h30", 30, 0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 31, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        reset = 1'b1;
        #1;
        check_val("t5.async.valid", 64'(dut_if.out_valid), 64'd0);
        check_val("t5.async.count", 64'(dut_if.fifo_count), 64'd0);
        check_val("t5.async.data",  64'(dut_if.out_data), 64'd0);
        check_val("t5.async.first", 64'(dut_if.out_first), 64'd0);
        step(1'b0, 1'b0, 0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 0, 1'b1);
            check_val($sformatf("t5.no_partial%0d", i), 64'(dut_if.out_valid), 64'd0);
        end
        step(1'b1, 1'b0, 32, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 0, 1'b0);
        check_head("t5.h32", 32, 0, 1'b1, 1'b0);
        check_val("t5.count", 64'(dut_if.fifo_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
